// File: rtl/spdot_idx_writer.sv
// spdot_idx_writer: unpacks a stream of 32-bit beats (two 16-bit block ids each)
// into sequential 16-bit writes to the BSR block-index RAM, with per-entry
// range checks and a running count/checksum for firmware load confirmation.
//
// state  | meaning
// IDLE   | waiting for start; load parameters latched on start
// ACCEPT | in_ready high; a handshake writes the low half next cycle
// WR_HI  | writing the held high half of the last beat
// DONE   | load finished; done pulses on the following cycle
module spdot_idx_writer #(
  parameter int IDX_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] num_entries,
  input  logic [15:0] max_block,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        idx_wr_en,
  output logic [15:0] idx_wr_addr,
  output logic [15:0] idx_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] count_out,
  output logic [31:0] checksum_out
);

  // 17 bits so a depth of 65536 still compares correctly against a 16-bit pointer
  localparam logic [16:0] DEPTH_L = 17'(IDX_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCEPT, WR_HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] ptr;
  logic [15:0] rem;
  logic [15:0] bound;
  logic [15:0] hold;
  logic        hs;
  logic        ent_act;
  logic [15:0] ent_data;
  logic        ent_fault;

  assign hs = in_valid && in_ready;

  // Select the entry occupying the current write slot and range-check it
  always_comb begin
    ent_act   = (state == ACCEPT && hs) || (state == WR_HI);
    ent_data  = (state == WR_HI) ? hold : in_data[15:0];
    ent_fault = (ent_data >= bound) || ({1'b0, ptr} >= DEPTH_L);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; rem==1 means the slot being consumed now is the last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_entries == 16'd0) ? DONE : ACCEPT;
      ACCEPT:  if (hs)    state_nxt = (rem == 16'd1) ? DONE : WR_HI;
      WR_HI:   state_nxt = (rem == 16'd1) ? DONE : ACCEPT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == ACCEPT);
    busy     = (state == ACCEPT) || (state == WR_HI);
  end

  // Datapath: load parameters, issue writes, accumulate count/checksum/error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr          <= '0;
      rem          <= '0;
      bound        <= '0;
      hold         <= '0;
      idx_wr_en    <= 1'b0;
      idx_wr_addr  <= '0;
      idx_wr_data  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      count_out    <= '0;
      checksum_out <= '0;
    end else begin
      idx_wr_en <= 1'b0;
      done      <= (state == DONE);
      if (state == IDLE && start) begin
        ptr          <= base_addr;
        rem          <= num_entries;
        bound        <= max_block;
        count_out    <= '0;
        checksum_out <= '0;
        error        <= 1'b0;
      end
      if (state == ACCEPT && hs) hold <= in_data[31:16];
      if (ent_act) begin
        ptr <= ptr + 16'd1;
        rem <= rem - 16'd1;
        if (ent_fault) begin
          error <= 1'b1;
        end else begin
          idx_wr_en    <= 1'b1;
          idx_wr_addr  <= ptr;
          idx_wr_data  <= ent_data;
          count_out    <= count_out + 16'd1;
          checksum_out <= checksum_out + {16'd0, ent_data};
        end
      end
    end
  end

endmodule
